// File: rtl/sink_buf_pkg.sv
// Shared definitions for the receive-side sink buffer controller.
// Holds the controller state encoding and the default geometry constants.
// No logic; imported by sink_buf_ctrl and sink_xor_acc.
package sink_buf_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_HDR_BYTES = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FULL    = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_RD_OUT  = 3'd6
  } sink_state_t;

endpackage

// File: rtl/sink_xor_acc.sv
// Purpose: running XOR of accepted bytes, cleared at the start of each frame.
// Latency: acc reflects a byte on the cycle after its enable; clear wins over enable.
// Backpressure: none; consumes one byte per enabled cycle.
// Ports: clk, reset (async high), clear, enable, din[7:0] -> acc[7:0].
// Only compiled when SINK_BUF_CHECKSUM_EN is defined (the only user sits under it).
`ifdef SINK_BUF_CHECKSUM_EN
module sink_xor_acc
  import sink_buf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= 8'h00;
    end else if (clear) begin
      acc <= 8'h00;
    end else if (enable) begin
      acc <= acc ^ din;
    end
  end

endmodule
`endif

// File: rtl/sink_buf_ctrl.sv
// Purpose: sequences single-port f_mem between header-stripping byte capture and frame readout.
// Latency: writes go to f_mem combinationally (0 cycles); readout byte valid 3 cycles after rd_start / after each accept.
// Backpressure: rd_valid/rd_data held until rd_ready; no write backpressure, bytes arriving while FULL are dropped (overflow).
// Ports: clk, reset (async high); start_sink, wr_valid/wr_data/wr_last in; rd_start, rd_ready in,
//        rd_valid/rd_data out; mem_addr/mem_data/mem_wren to f_mem, mem_q from f_mem;
//        busy, frame_done, frame_len, overflow, checksum status.
// Optional: SINK_BUF_CHECKSUM_EN adds the payload XOR accumulator; otherwise checksum is 0.
module sink_buf_ctrl
  import sink_buf_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int HDR_BYTES = DEF_HDR_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_sink,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  input  logic              wr_last,
  input  logic              rd_start,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wren,
  input  logic [7:0]        mem_q,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W:0]   frame_len,
  output logic              overflow,
  output logic [7:0]        checksum
);

  localparam int HC_W = $clog2(HDR_BYTES + 2);
  localparam logic [HC_W-1:0]   HDR_LAST  = HC_W'((HDR_BYTES == 0) ? 0 : HDR_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  sink_state_t       state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [HC_W-1:0]   hdr_cnt;

  logic start_acc;   // start_sink honoured (ignored during readout)
  logic wr_acc;      // a byte that counts: a coincident start_sink voids it
  logic wr_end;      // final payload write of the frame
  logic hdr_end;     // last header byte discarded
  logic rd_accept;
  logic rd_end;      // consumer took the last stored byte

  always_comb begin
    start_acc = start_sink && (state_q inside {ST_IDLE, ST_HEADER, ST_CAPTURE, ST_FULL});
    wr_acc    = wr_valid && !start_sink;
    wr_end    = (state_q == ST_CAPTURE) && wr_acc && ((wr_ptr == LAST_ADDR) || wr_last);
    hdr_end   = (state_q == ST_HEADER) && wr_acc && (hdr_cnt == HDR_LAST);
    rd_accept = (state_q == ST_RD_OUT) && rd_ready;
    rd_end    = rd_accept && ({1'b0, rd_ptr} == (frame_len - 1'b1));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (start_acc) begin
      state_d = (HDR_BYTES == 0) ? ST_CAPTURE : ST_HEADER;
    end else begin
      case (state_q)
        ST_HEADER:  if (hdr_end) state_d = ST_CAPTURE;
        ST_CAPTURE: if (wr_end) state_d = ST_FULL;
        ST_FULL:    if (rd_start) state_d = ST_RD_ADDR;
        ST_RD_ADDR: state_d = ST_RD_WAIT;
        ST_RD_WAIT: state_d = ST_RD_OUT;
        ST_RD_OUT:  if (rd_accept) state_d = rd_end ? ST_FULL : ST_RD_ADDR;
        default:    state_d = state_q;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    mem_addr = rd_ptr;
    mem_data = 8'h00;
    mem_wren = 1'b0;
    rd_valid = (state_q == ST_RD_OUT);
    busy     = (state_q != ST_IDLE) && (state_q != ST_FULL);
    if ((state_q == ST_HEADER) || (state_q == ST_CAPTURE)) begin
      mem_addr = wr_ptr;
    end
    if (state_q == ST_CAPTURE) begin
      mem_data = wr_data;
      mem_wren = wr_acc;
    end
  end

  // Pointers, frame bookkeeping and readout data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hdr_cnt    <= '0;
      frame_len  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      rd_data    <= 8'h00;
    end else begin
      frame_done <= wr_end;
      if (start_acc) begin
        wr_ptr    <= '0;
        hdr_cnt   <= '0;
        frame_len <= '0;
        overflow  <= 1'b0;
      end else begin
        if ((state_q == ST_HEADER) && wr_acc) hdr_cnt <= hdr_cnt + 1'b1;
        if (mem_wren) wr_ptr <= wr_ptr + 1'b1;
        if (wr_end) frame_len <= {1'b0, wr_ptr} + 1'b1;
        if ((state_q == ST_FULL) && wr_acc) overflow <= 1'b1;
        if ((state_q == ST_FULL) && rd_start) rd_ptr <= '0;
      end
      // f_mem q is valid in RD_WAIT for the address presented in RD_ADDR
      if (state_q == ST_RD_WAIT) rd_data <= mem_q;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef SINK_BUF_CHECKSUM_EN
  sink_xor_acc u_xor_acc (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_acc),
    .enable (mem_wren),
    .din    (wr_data),
    .acc    (checksum)
  );
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_sink_buf_ctrl.sv
// Bench for sink_buf_ctrl: directed frames plus randomized frames, with an f_mem model
// and a frame-level reference (payload list, length, overflow, XOR) derived from the byte stream.
// Honours SINK_BUF_CHECKSUM_EN for the expected checksum.
module tb_sink_buf_ctrl;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 16;
  localparam int HDR    = 2;

  logic              clk;
  logic              reset;
  logic              start_sink;
  logic              wr_valid;
  logic [7:0]        wr_data;
  logic              wr_last;
  logic              rd_start;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic              rd_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_wren;
  logic [7:0]        mem_q;
  logic              busy;
  logic              frame_done;
  logic [ADDR_W:0]   frame_len;
  logic              overflow;
  logic [7:0]        checksum;

  sink_buf_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HDR_BYTES(HDR)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_sink (start_sink),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .rd_start   (rd_start),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .overflow   (overflow),
    .checksum   (checksum)
  );

  // f_mem: single port, registered read
  logic [7:0] fmem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_wren) fmem[mem_addr] <= mem_data;
    mem_q <= fmem[mem_addr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] tx_q[$];   // bytes offered, header included
  logic [7:0] exp_q[$];  // payload the model says is stored
  logic [7:0] csum;
  bit         ovf_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_csum();
`ifdef SINK_BUF_CHECKSUM_EN
    return csum;
`else
    return 8'h00;
`endif
  endfunction

  task automatic check_reset_vals();
    check("rst_wren", 32'(mem_wren), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_mdata", 32'(mem_data), 0);
    check("rst_rdvalid", 32'(rd_valid), 0);
    check("rst_rddata", 32'(rd_data), 0);
    check("rst_fdone", 32'(frame_done), 0);
    check("rst_flen", 32'(frame_len), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_csum", 32'(checksum), 0);
  endtask

  task automatic start(input bit with_wr, input bit with_rd);
    start_sink = 1'b1; wr_valid = with_wr; wr_data = 8'h5A; wr_last = 1'b0; rd_start = with_rd;
    #1;
    check("start_wren", 32'(mem_wren), 0);
    cyc();
    start_sink = 1'b0; wr_valid = 1'b0; rd_start = 1'b0;
    #1;
    check("start_busy", 32'(busy), 1);
    check("start_flen", 32'(frame_len), 0);
    check("start_ovf", 32'(overflow), 0);
    check("start_csum", 32'(checksum), 0);
    check("start_rdvalid", 32'(rd_valid), 0);
    check("start_addr", 32'(mem_addr), 0);
    ovf_exp = 1'b0;
  endtask

  // Offers tx_q; byte index last_idx carries wr_last (-1: none)
  task automatic send_frame(input int last_idx, input bit gaps);
    bit done, prev_final, fin, was_done;
    int p;
    done = 0; prev_final = 0;
    exp_q.delete(); csum = 8'h00;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 2));
        for (int j = 0; j < g; j++) begin
          wr_valid = 1'b0; wr_last = 1'b0;
          #1;
          check("gap_wren", 32'(mem_wren), 0);
          check("gap_fdone", 32'(frame_done), 32'(prev_final));
          cyc();
          prev_final = 0;
        end
      end
      wr_valid = 1'b1; wr_data = tx_q[i]; wr_last = (i == last_idx);
      #1;
      was_done = done; fin = 0;
      p = i - HDR;
      if (i >= HDR && !done) begin
        check("wr_wren", 32'(mem_wren), 1);
        check("wr_addr", 32'(mem_addr), p);
        check("wr_data", 32'(mem_data), 32'(tx_q[i]));
        exp_q.push_back(tx_q[i]);
        csum ^= tx_q[i];
        if (p == DEPTH - 1 || i == last_idx) begin
          done = 1; fin = 1;
        end
      end else begin
        check("wr_nowren", 32'(mem_wren), 0);
      end
      check("wr_ovf", 32'(overflow), 32'(ovf_exp));
      check("wr_fdone", 32'(frame_done), 32'(prev_final));
      check("wr_busy", 32'(busy), 32'(!was_done));
      cyc();
      prev_final = fin;
      if (was_done) ovf_exp = 1'b1;
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    #1;
    check("end_fdone", 32'(frame_done), 32'(prev_final));
    check("end_wren", 32'(mem_wren), 0);
    cyc();
    check("post_fdone", 32'(frame_done), 0);
    check("frame_len", 32'(frame_len), done ? exp_q.size() : 0);
    check("end_busy", 32'(busy), 32'(!done));
    check("end_ovf", 32'(overflow), 32'(ovf_exp));
    check("checksum", 32'(checksum), 32'(exp_csum()));
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low 10 cycles on byte 1
  task automatic read_frame(input int mode);
    int k, budget, gap, stall;
    bit go;
    k = 0; budget = 0; gap = 0; stall = 0;
    rd_start = 1'b1; rd_ready = (mode == 0);
    cyc();
    rd_start = 1'b0;
    check("rd_lat1", 32'(rd_valid), 0);
    cyc();
    check("rd_lat2", 32'(rd_valid), 0);
    cyc();
    check("rd_lat3", 32'(rd_valid), 1);
    while (k < exp_q.size() && budget < 500) begin
      if (rd_valid) begin
        check("rd_data", 32'(rd_data), 32'(exp_q[k]));
        check("rd_ptr", 32'(mem_addr), k);
        check("rd_wren", 32'(mem_wren), 0);
        if (mode == 0 && k > 0) check("rd_gap", gap, 3);
        go = (mode == 0) || (mode == 1 && $urandom_range(0, 2) != 0) ||
             (mode == 2 && (k != 1 || stall >= 10));
        if (!go) stall++;
        rd_ready = go;
        if (go) gap = 0;
        cyc();
        if (go) k++;
      end else begin
        if (mode != 0) rd_ready = 1'($urandom_range(0, 1));
        cyc();
      end
      gap++;
      budget++;
    end
    check("rd_count", k, exp_q.size());
    rd_ready = 1'b0;
    cyc();
    check("rd_after_valid", 32'(rd_valid), 0);
    check("rd_after_busy", 32'(busy), 0);
  endtask

  task automatic build_frame(input int n_payload, input int first);
    tx_q.delete();
    for (int i = 0; i < HDR; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < n_payload; i++)
      tx_q.push_back((first < 0) ? 8'($urandom_range(0, 255)) : 8'(first + i));
  endtask

  initial begin
    reset = 1'b1; start_sink = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; wr_last = 1'b0;
    rd_start = 1'b0; rd_ready = 1'b0; ovf_exp = 1'b0; csum = 8'h00;
    cyc(); cyc();
    check_reset_vals();
    reset = 1'b0;
    cyc();

    // Idle ignores writes and read requests
    wr_valid = 1'b1; rd_start = 1'b1; wr_data = 8'h33;
    #1;
    check("idle_wren", 32'(mem_wren), 0);
    cyc(); cyc();
    wr_valid = 1'b0; rd_start = 1'b0;
    check("idle_busy", 32'(busy), 0);
    check("idle_rdvalid", 32'(rd_valid), 0);

    // AA BB header then 0x00..0x0F fills the buffer
    start(1'b1, 1'b0);
    tx_q = {8'hAA, 8'hBB};
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(i));
    send_frame(-1, 1'b0);
    read_frame(0);

    // 5-byte frame ended by wr_last, read twice (second with a long stall)
    start(1'b0, 1'b0);
    build_frame(5, 8'h40);
    send_frame(HDR + 4, 1'b0);
    read_frame(0);
    read_frame(2);

    // 17 payload bytes: last one dropped, overflow sticky until next start
    start(1'b0, 1'b0);
    build_frame(17, -1);
    send_frame(-1, 1'b0);
    read_frame(1);
    check("ovf_sticky", 32'(overflow), 1);

    // Small XOR frame; start_sink beats a simultaneous rd_start in FULL
    start(1'b0, 1'b1);
    tx_q = {8'h11, 8'h22, 8'h01, 8'h02, 8'h04};
    send_frame(4, 1'b0);
    check("csum_107", 32'(checksum), 32'(exp_csum()));

    // Restart mid-capture with a coincident byte
    start(1'b0, 1'b0);
    build_frame(4, -1);
    send_frame(-1, 1'b0);
    start(1'b1, 1'b0);
    build_frame(6, 8'h80);
    send_frame(HDR + 5, 1'b1);
    read_frame(1);

    // Reset in the middle of a capture
    start(1'b0, 1'b0);
    build_frame(7, -1);
    send_frame(-1, 1'b0);
    wr_valid = 1'b1; wr_data = 8'hEE;
    reset = 1'b1;
    #1;
    wr_valid = 1'b0;
    cyc();
    check_reset_vals();
    reset = 1'b0; ovf_exp = 1'b0;
    cyc();
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_rd_ignored", 32'(rd_valid), 0);
      cyc();
    end
    start(1'b0, 1'b0);
    build_frame(3, 8'hC0);
    send_frame(HDR + 2, 1'b0);
    read_frame(0);

    // Randomized frames
    for (int it = 0; it < 25; it++) begin
      int n, li;
      start(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n = int'($urandom_range(1, 20));
      build_frame(n, -1);
      li = ($urandom_range(0, 1) != 0) ? HDR + int'($urandom_range(0, n - 1)) : -1;
      send_frame(li, 1'b1);
      if (!busy) read_frame(($urandom_range(0, 2) == 0) ? 0 : 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
